// File: rtl/bq_pkg.sv
// Shared constants for the biquad coefficient sequencer: coefficient indices and FSM encoding.
package bq_pkg;

  localparam int NUM_COEF = 5;

  localparam logic [2:0] IDX_A11 = 3'd0;
  localparam logic [2:0] IDX_A12 = 3'd1;
  localparam logic [2:0] IDX_B10 = 3'd2;
  localparam logic [2:0] IDX_B11 = 3'd3;
  localparam logic [2:0] IDX_B12 = 3'd4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

endpackage

// File: rtl/bq_coef_sequencer_if.sv
// Wishbone master-side write bus between the coefficient sequencer and the filter's slave port.
interface bq_coef_sequencer_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;

  modport master (output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
                  input  wbm_ack_i);
  modport slave  (input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
                  output wbm_ack_i);
endinterface

// File: rtl/bq_coef_sequencer_bank.sv
// Coefficient bank: NSETS x NUM_COEF registers with one write port and a whole-set read port.
module bq_coef_bank
  import bq_pkg::*;
#(
  parameter int COEFWIDTH = 16,
  parameter int SETW      = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   we,
  input  logic [SETW-1:0]                        wsel,
  input  logic [2:0]                             widx,
  input  logic [COEFWIDTH-1:0]                   wdat,
  input  logic [SETW-1:0]                        rsel,
  output logic [NUM_COEF-1:0][COEFWIDTH-1:0]     rdata
);

  localparam int NSETS = 2 ** SETW;

  logic [NSETS-1:0][NUM_COEF-1:0][COEFWIDTH-1:0] bank_q, bank_d;

  // NOTE: combinational blocks use blocking '=' and assign a default first, so no latch is inferred.
  always_comb begin
    bank_d = bank_q;
    if (we && (widx <= IDX_B12)) begin
      bank_d[wsel][widx] = wdat;
    end
  end

  // NOTE: the bank is a small register file that must read as zero after reset, so it is reset
  // explicitly; sequential state uses non-blocking '<=' only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign rdata = bank_q[rsel];

endmodule

// File: rtl/bq_coef_sequencer.sv
// Writes one snapshotted biquad coefficient set to the filter as five single-beat Wishbone writes.
module bq_coef_sequencer
  import bq_pkg::*;
#(
  parameter int          COEFWIDTH = 16,
  parameter int          SETW      = 2,
  parameter logic [31:0] BASE_ADR  = 32'h0,
  parameter int          TIMEOUT   = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  nreset,
  input  logic                  set_we,
  input  logic [SETW-1:0]       set_sel,
  input  logic [2:0]            set_idx,
  input  logic [COEFWIDTH-1:0]  set_dat,
  input  logic                  start,
  input  logic [SETW-1:0]       start_set,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [SETW-1:0]       active_set,
  bq_coef_sequencer_if.master   wbm
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]                            state_q, state_d;
  logic [2:0]                            k_q, k_d;
  logic [TW-1:0]                         tmo_q, tmo_d;
  logic [NUM_COEF-1:0][COEFWIDTH-1:0]    shadow_q, shadow_d;
  logic [SETW-1:0]                       cur_set_q, cur_set_d;
  logic [SETW-1:0]                       active_set_q, active_set_d;
  logic [NUM_COEF-1:0][COEFWIDTH-1:0]    bank_rd;

  bq_coef_bank #(
    .COEFWIDTH (COEFWIDTH),
    .SETW      (SETW)
  ) u_bank (
    .clk   (wb_clk_i),
    .rst_n (nreset),
    .we    (set_we),
    .wsel  (set_sel),
    .widx  (set_idx),
    .wdat  (set_dat),
    .rsel  (start_set),
    .rdata (bank_rd)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    tmo_d        = tmo_q;
    shadow_d     = shadow_q;
    cur_set_d    = cur_set_q;
    active_set_d = active_set_q;
    case (state_q)
      ST_IDLE: begin
        // Snapshot reads the registered bank, so a same-cycle bank write is not captured.
        if (start) begin
          shadow_d  = bank_rd;
          cur_set_d = start_set;
          k_d       = IDX_A11;
          tmo_d     = '0;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wbm.wbm_ack_i) begin
          if (k_q == IDX_B12) begin
            state_d      = ST_DONE;
            active_set_d = cur_set_q;
          end else begin
            state_d = ST_GAP;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_GAP: begin
        k_d     = k_q + 3'd1;
        tmo_d   = '0;
        state_d = ST_WRITE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      tmo_q        <= '0;
      shadow_q     <= '0;
      cur_set_q    <= '0;
      active_set_q <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      tmo_q        <= tmo_d;
      shadow_q     <= shadow_d;
      cur_set_q    <= cur_set_d;
      active_set_q <= active_set_d;
    end
  end

  logic cyc;
  assign cyc = (state_q == ST_WRITE) || (state_q == ST_GAP);

  assign wbm.wbm_cyc_o = cyc;
  assign wbm.wbm_stb_o = (state_q == ST_WRITE);
  assign wbm.wbm_we_o  = cyc;
  assign wbm.wbm_adr_o = cyc ? (BASE_ADR + 32'(k_q)) : 32'h0;
  assign wbm.wbm_dat_o = cyc ? 32'($signed(shadow_q[k_q])) : 32'h0;

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);
  assign active_set = active_set_q;

endmodule

// File: tb/tb_bq_coef_sequencer.sv
// Scoreboard bench for bq_coef_sequencer: a behavioural bank model predicts beats and outcomes.
module tb_bq_coef_sequencer;

  localparam int          CW      = 16;
  localparam int          SW      = 2;
  localparam logic [31:0] BASE    = 32'h0;
  localparam int          TMO     = 16;

  logic          wb_clk_i = 1'b0;
  logic          nreset   = 1'b0;
  logic          set_we   = 1'b0;
  logic [SW-1:0] set_sel  = '0;
  logic [2:0]    set_idx  = '0;
  logic [CW-1:0] set_dat  = '0;
  logic          start    = 1'b0;
  logic [SW-1:0] start_set = '0;
  logic          busy, done, err;
  logic [SW-1:0] active_set;

  bq_coef_sequencer_if wbm ();

  bq_coef_sequencer #(
    .COEFWIDTH (CW),
    .SETW      (SW),
    .BASE_ADR  (BASE),
    .TIMEOUT   (TMO)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .nreset     (nreset),
    .set_we     (set_we),
    .set_sel    (set_sel),
    .set_idx    (set_idx),
    .set_dat    (set_dat),
    .start      (start),
    .start_set  (start_set),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .active_set (active_set),
    .wbm        (wbm)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bank contents, last completed set, expected beats and outcomes.
  logic [CW-1:0] mbank [4][5];
  logic [SW-1:0] exp_active = '0;

  typedef struct { logic [31:0] adr; logic [31:0] dat; } beat_t;
  typedef struct { bit is_err; logic [SW-1:0] act; } out_t;
  beat_t beat_q[$];
  out_t  out_q[$];

  function automatic logic [31:0] sext(input logic [CW-1:0] v);
    return {{(32-CW){v[CW-1]}}, v};
  endfunction

  // Slave behaviour knobs.
  int waits = 0;
  int hang_idx = -1;

  initial begin
    int wcnt;
    wcnt = 0;
    wbm.wbm_ack_i = 1'b0;
    forever begin
      @(posedge wb_clk_i);
      #1;
      if (!nreset) begin
        wcnt = 0;
        wbm.wbm_ack_i = 1'b0;
      end else if (wbm.wbm_stb_o) begin
        wbm.wbm_ack_i = (wcnt == waits) && (int'(wbm.wbm_adr_o - BASE) != hang_idx);
        wcnt++;
      end else begin
        wcnt = 0;
        wbm.wbm_ack_i = ($urandom_range(0, 3) == 0);  // stray acks outside stb must be ignored
      end
    end
  end

  // Monitor: compares every accepted beat and every done/err pulse against the scoreboard.
  initial begin
    beat_t b;
    out_t  o;
    forever begin
      @(negedge wb_clk_i);
      if (nreset && wbm.wbm_cyc_o) check("we_with_cyc", wbm.wbm_we_o, 1'b1);
      if (wbm.wbm_cyc_o && wbm.wbm_stb_o && wbm.wbm_ack_i) begin
        if (beat_q.size() == 0) begin
          check("beat_unexpected", 1'b1, 1'b0);
        end else begin
          b = beat_q.pop_front();
          check("beat_adr", wbm.wbm_adr_o, b.adr);
          check("beat_dat", wbm.wbm_dat_o, b.dat);
        end
      end
      if (done || err) begin
        if (out_q.size() == 0) begin
          check("outcome_unexpected", 1'b1, 1'b0);
        end else begin
          o = out_q.pop_front();
          check("outcome_done_err", {done, err}, o.is_err ? 2'b01 : 2'b10);
          if (!o.is_err) check("outcome_active_set", active_set, o.act);
          check("beats_left_at_end", beat_q.size(), 0);
        end
      end
    end
  end

  task automatic write_bank(input int s, input int idx, input logic [CW-1:0] v);
    @(negedge wb_clk_i);
    set_we = 1'b1; set_sel = SW'(s); set_idx = 3'(idx); set_dat = v;
    if (idx <= 4) mbank[s][idx] = v;
    @(negedge wb_clk_i);
    set_we = 1'b0;
  endtask

  // One transfer: pushes predictions, pulses start, measures latency and stb occupancy.
  task automatic run_xfer(input int s, input int w, input int hang, input int inj_cycle,
                          input bit same_wr, input logic [CW-1:0] same_val);
    int n, stbs, exp_n, exp_stbs, widx;
    bit finished;
    waits = w;
    hang_idx = hang;
    @(negedge wb_clk_i);
    for (int k = 0; k < 5; k++)
      if (hang < 0 || k < hang) beat_q.push_back('{adr: BASE + 32'(k), dat: sext(mbank[s][k])});
    if (hang < 0) exp_active = SW'(s);
    out_q.push_back('{is_err: (hang >= 0), act: exp_active});
    start = 1'b1;
    start_set = SW'(s);
    if (same_wr) begin
      widx = $urandom_range(0, 4);
      set_we = 1'b1; set_sel = SW'(s); set_idx = 3'(widx); set_dat = same_val;
      mbank[s][widx] = same_val;
    end
    n = 0; stbs = 0; finished = 1'b0;
    while (!finished && n < 400) begin
      @(negedge wb_clk_i);
      n++;
      start = 1'b0;
      set_we = 1'b0;
      if (n == 1) check("busy_after_start", busy, 1'b1);
      if (wbm.wbm_stb_o) stbs++;
      if (n == inj_cycle) begin
        set_we = 1'b1; set_sel = SW'(s); set_idx = 3'd4; set_dat = 16'h1234;
        mbank[s][4] = 16'h1234;
        start = 1'b1; start_set = SW'((s + 1) % 4);
      end
      if (done || err) finished = 1'b1;
    end
    check("xfer_finished", finished, 1'b1);
    exp_n    = (hang < 0) ? 5 * (w + 1) + 5 : hang * (w + 2) + TMO + 1;
    exp_stbs = (hang < 0) ? 5 * (w + 1)     : hang * (w + 1) + TMO;
    check("xfer_cycles", n, exp_n);
    check("xfer_stb_cycles", stbs, exp_stbs);
    @(negedge wb_clk_i);
    check("busy_after_end", busy, 1'b0);
    check("cyc_after_end", wbm.wbm_cyc_o, 1'b0);
    check("active_set_after_end", active_set, exp_active);
    @(negedge wb_clk_i);
    check("still_idle", busy, 1'b0);
  endtask

  task automatic reset_mid_transfer();
    int n;
    for (int k = 0; k < 5; k++) write_bank(1, k, 16'(16'h0100 + k));
    waits = 3;
    hang_idx = -1;
    @(negedge wb_clk_i);
    for (int k = 0; k < 5; k++) beat_q.push_back('{adr: BASE + 32'(k), dat: sext(mbank[1][k])});
    out_q.push_back('{is_err: 1'b0, act: SW'(1)});
    start = 1'b1; start_set = SW'(1);
    for (n = 1; n <= 7; n++) begin
      @(negedge wb_clk_i);
      start = 1'b0;
    end
    check("rst_pre_stb", wbm.wbm_stb_o, 1'b1);
    #2 nreset = 1'b0;
    #1;
    check("rst_async_cyc", wbm.wbm_cyc_o, 1'b0);
    check("rst_async_stb", wbm.wbm_stb_o, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    beat_q.delete();
    out_q.delete();
    for (int s = 0; s < 4; s++) for (int k = 0; k < 5; k++) mbank[s][k] = '0;
    exp_active = '0;
    repeat (3) @(negedge wb_clk_i);
    nreset = 1'b1;
    @(negedge wb_clk_i);
    check("rst_active_set", active_set, '0);
    waits = 0;
    run_xfer(1, 0, -1, 0, 1'b0, '0);
  endtask

  initial begin
    for (int s = 0; s < 4; s++) for (int k = 0; k < 5; k++) mbank[s][k] = '0;
    repeat (3) @(negedge wb_clk_i);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_active_set", active_set, '0);
    check("reset_cyc", wbm.wbm_cyc_o, 1'b0);
    check("reset_stb", wbm.wbm_stb_o, 1'b0);
    check("reset_adr", wbm.wbm_adr_o, 32'h0);
    check("reset_dat", wbm.wbm_dat_o, 32'h0);
    nreset = 1'b1;

    write_bank(1, 0, 16'h4001);
    write_bank(1, 1, 16'hC000);
    write_bank(1, 2, 16'h2000);
    write_bank(1, 3, 16'h0000);
    write_bank(1, 4, 16'hFFFF);
    run_xfer(1, 0, -1, 0, 1'b0, '0);
    run_xfer(1, 3, -1, 0, 1'b0, '0);

    for (int k = 0; k < 5; k++) write_bank(2, k, 16'($urandom));
    for (int k = 0; k < 5; k++) write_bank(3, k, 16'($urandom));
    run_xfer(2, 0, 2, 0, 1'b0, '0);
    run_xfer(2, 0, -1, 3, 1'b0, '0);
    run_xfer(2, 0, -1, 0, 1'b0, '0);

    write_bank(0, 2, 16'h8001);
    write_bank(0, 6, 16'hBEEF);
    write_bank(0, 5, 16'h1111);
    write_bank(0, 7, 16'h2222);
    run_xfer(0, 1, -1, 0, 1'b0, '0);

    run_xfer(3, 1, -1, 0, 1'b1, 16'h7ABC);
    run_xfer(3, 0, -1, 0, 1'b0, '0);

    reset_mid_transfer();

    for (int t = 0; t < 20; t++) begin
      int s, w, h;
      repeat ($urandom_range(1, 5)) write_bank($urandom_range(0, 3), $urandom_range(0, 7), 16'($urandom));
      s = $urandom_range(0, 3);
      w = $urandom_range(0, 3);
      h = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 4) : -1;
      run_xfer(s, w, h, 0, 1'($urandom_range(0, 1)), 16'($urandom));
    end

    check("final_beats_empty", beat_q.size(), 0);
    check("final_outcomes_empty", out_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
